pic_cpu_bus_master: RTL
=======================

# pic_cpu_bus_master

- CPU-side bus initiator for the 8259A-style PIC data bus.
- Converts single-cycle requests from a processor model or test harness into 8259A bus cycles: ICW/OCW writes, status reads, and the two-pulse INTA sequence that fetches the interrupt vector.
- Drives the tri-state `Ds` bus on writes only and samples it on reads and on the second INTA.
- Sits opposite the PIC's data bus buffer and write/read logic, on the same `Ds` wires.

## Interface

Parameters:
- `SETUP_CYC`, default 1: cycles with `cs_n`/`a0` (and write data) valid before the strobe falls. Must be ≥1.
- `PULSE_CYC`, default 2: cycles `rd_n`, `wr_n` or `inta_n` is held low. Must be ≥1.
- `HOLD_CYC`, default 1: cycles `cs_n`/`a0`/write data are held after the strobe rises. Must be ≥1.
- `GAP_CYC`, default 2: cycles `inta_n` is high between the two INTA pulses. Must be ≥1.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request. High only in IDLE and not while `reset` is asserted.
- `req_op` in 2: operation code. 00 = write, 01 = read, 10 = INTA, 11 = illegal.
- `req_a0` in 1: A0 for write and read.
- `req_data` in 8: write data.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out 8: read data or vector. Held until the next completion.
- `rsp_err` out 1: valid with `rsp_valid`; high for an illegal op.
- `cs_n`, `rd_n`, `wr_n`, `inta_n` out 1 each: active-low PIC bus strobes.
- `a0` out 1: address line to the PIC.
- `Ds` inout 8: PIC data bus.
- `int_in` in 1: INT from the PIC, asynchronous.
- `int_seen` out 1: `int_in` after a two-flop synchronizer.

## Operation

States: IDLE, SETUP, STROBE, HOLD, INTA1, GAP, INTA2, DONE.

- **Accept:** a request is taken on an edge with `req_valid && req_ready`. `req_op`, `req_a0` and `req_data` are registered at that edge and are ignored afterwards.
- **Write (op 00):**
  - Sequence: SETUP (`SETUP_CYC`) → STROBE (`PULSE_CYC`) → HOLD (`HOLD_CYC`) → DONE.
  - `cs_n` = 0 and `a0` = registered A0 throughout SETUP, STROBE and HOLD.
  - `wr_n` = 0 only in STROBE.
  - `Ds` driven with the registered data in SETUP, STROBE and HOLD; high-Z in every other state.
- **Read (op 01):**
  - Same sequence as a write, with `rd_n` = 0 in STROBE.
  - `Ds` is never driven during a read.
  - `Ds` is captured into `rsp_data` at the edge ending the last STROBE cycle.
- **INTA (op 10):**
  - Sequence: INTA1 (`PULSE_CYC`) → GAP (`GAP_CYC`) → INTA2 (`PULSE_CYC`) → DONE.
  - `inta_n` = 0 in INTA1 and INTA2.
  - `cs_n` = 1 and `a0` = 0 throughout.
  - `Ds` is captured at the edge ending the last INTA2 cycle. Bus content during INTA1 is ignored.
- **Illegal op (11):** goes directly to DONE. No strobe is asserted; `rsp_err` = 1 and `rsp_data` is unchanged.
- **DONE:**
  - Lasts exactly 1 cycle.
  - `rsp_valid` = 1; all strobes high; `Ds` high-Z; `req_ready` = 0.
  - This guarantees a bus turnaround cycle.
  - Next state is IDLE.
- **Counters:** one down-counter, wide enough for the largest parameter, reloaded on every state entry.
- **Write-data latch:** independent of the response register.
- **Strobe outputs:** registered, so they are glitch-free.

## Timing

- **Reset:** while `reset` is asserted, every output is forced at each edge:
  - `cs_n`, `rd_n`, `wr_n`, `inta_n` = 1
  - `a0` = 0, `Ds` = Z
  - `rsp_valid` = 0, `rsp_data` = 0x00, `rsp_err` = 0
  - `int_seen` = 0, state = IDLE
- **Reset mid-transaction:** aborts at the next edge. No `rsp_valid` is produced.
- **Write/read latency with defaults (1/2/1):** numbering cycles from the accept edge,
  - SETUP in cycle 1,
  - STROBE in cycles 2–3,
  - HOLD in cycle 4,
  - `rsp_valid` in cycle 5,
  - `req_ready` high again in cycle 6.
- **General write/read latency:** `rsp_valid` occurs `SETUP_CYC + PULSE_CYC + HOLD_CYC + 1` cycles after accept.
- **INTA latency:** `rsp_valid` occurs `2*PULSE_CYC + GAP_CYC + 1` cycles after accept; with defaults this is cycle 7.
- **Illegal op latency:** `rsp_valid` occurs 1 cycle after accept.
- **Back-to-back requests:** minimum spacing is one DONE cycle plus one IDLE cycle. `req_valid` may stay high throughout.
- **`int_seen`:** lags `int_in` by 2 edges. It is independent of the transaction state.

## Test plan

- Write, `req_op`=00, `a0`=0, data 0x13 (ICW1):
  - `Ds` = 0x13 during cycles 1–4.
  - `wr_n` low in cycles 2–3 only.
  - `cs_n` low in cycles 1–4.
  - `rsp_valid` in cycle 5 with `rsp_err` = 0.
- Read, `a0`=1, with the PIC model driving 0xA5 while `rd_n` is low:
  - `rsp_data` = 0xA5 at cycle 5.
  - The DUT never drives `Ds` (no X contention).
- INTA, with the PIC model driving 0x20 on the first pulse and 0x48 on the second:
  - Two `inta_n` pulses of 2 cycles each, separated by a 2-cycle gap.
  - `cs_n` stays high throughout.
  - `rsp_data` = 0x48 at cycle 7.
- Back-to-back write 0x1F then read, with `req_valid` held high:
  - Second SETUP starts exactly 2 cycles after the first DONE.
  - Strobes are never simultaneously low.
- `reset` asserted during write STROBE:
  - Next edge: `wr_n` = 1, `cs_n` = 1, `Ds` = Z.
  - No `rsp_valid`.
  - `req_ready` = 1 one cycle after `reset` deasserts.
- Illegal op 11, then `int_in` raised:
  - `rsp_valid` and `rsp_err` = 1 one cycle after accept.
  - No strobe activity.
  - `int_seen` rises 2 edges after `int_in`.

Source files
------------

// File: rtl/pic_cpu_bus_master.sv
// CPU-side initiator for the 8259A-style PIC data bus.
// Turns single-cycle requests into write, read and two-pulse INTA cycles.
module pic_cpu_bus_master #(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int GAP_CYC   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic       req_a0,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       inta_n,
  output logic       a0,
  inout  wire  [7:0] Ds,
  input  logic       int_in,
  output logic       int_seen
);

  localparam int M1   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int M2   = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int MAXC = (M1 > M2) ? M1 : M2;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_PULSE = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_GAP   = CW'(GAP_CYC - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_INTA1  = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;
  localparam logic [2:0] S_INTA2  = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_INTA = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic          a0_lat_q, a0_lat_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          cs_n_q, cs_n_d;
  logic          rd_n_q, rd_n_d;
  logic          wr_n_q, wr_n_d;
  logic          inta_n_q, inta_n_d;
  logic          a0_q, a0_d;
  logic          ds_oe_q, ds_oe_d;
  logic          sync1_q, sync2_q;
  logic          last;
  logic          bus_d;

  assign req_ready = (state_q == S_IDLE) && !reset;
  assign last      = (cnt_q == '0);

  // Sequencer: state, phase counter, request latches and read capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a0_lat_d   = a0_lat_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          op_d     = req_op;
          a0_lat_d = req_a0;
          wdata_d  = req_data;
          unique case (1'b1)
            (req_op == OP_INTA): begin
              state_d = S_INTA1;
              cnt_d   = LD_PULSE;
            end
            (req_op == OP_ILL): begin
              state_d = S_DONE;
              cnt_d   = '0;
            end
            default: begin
              state_d = S_SETUP;
              cnt_d   = LD_SETUP;
            end
          endcase
        end
      end
      S_SETUP: begin
        if (last) begin
          state_d = S_STROBE;
          cnt_d   = LD_PULSE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STROBE: begin
        if (last) begin
          state_d = S_HOLD;
          cnt_d   = LD_HOLD;
          if (op_q == OP_RD) rsp_data_d = Ds;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (last) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_INTA1: begin
        if (last) begin
          state_d = S_GAP;
          cnt_d   = LD_GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (last) begin
          state_d = S_INTA2;
          cnt_d   = LD_PULSE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_INTA2: begin
        if (last) begin
          state_d    = S_DONE;
          cnt_d      = '0;
          rsp_data_d = Ds;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Bus pins derived from the next state so they come straight off flops
  always_comb begin
    bus_d = (state_d == S_SETUP) || (state_d == S_STROBE) ||
            (state_d == S_HOLD);
    cs_n_d      = !bus_d;
    a0_d        = bus_d && a0_lat_d;
    ds_oe_d     = bus_d && (op_d == OP_WR);
    wr_n_d      = !((state_d == S_STROBE) && (op_d == OP_WR));
    rd_n_d      = !((state_d == S_STROBE) && (op_d == OP_RD));
    inta_n_d    = !((state_d == S_INTA1) || (state_d == S_INTA2));
    rsp_valid_d = (state_d == S_DONE);
    rsp_err_d   = (state_d == S_DONE) && (op_d == OP_ILL);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_WR;
      a0_lat_q    <= 1'b0;
      wdata_q     <= 8'h00;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      inta_n_q    <= 1'b1;
      a0_q        <= 1'b0;
      ds_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a0_lat_q    <= a0_lat_d;
      wdata_q     <= wdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      inta_n_q    <= inta_n_d;
      a0_q        <= a0_d;
      ds_oe_q     <= ds_oe_d;
    end
  end

  // Two-flop synchronizer for the asynchronous INT line
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= int_in;
      sync2_q <= sync1_q;
    end
  end

  assign Ds        = ds_oe_q ? wdata_q : 8'hzz;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign cs_n      = cs_n_q;
  assign rd_n      = rd_n_q;
  assign wr_n      = wr_n_q;
  assign inta_n    = inta_n_q;
  assign a0        = a0_q;
  assign int_seen  = sync2_q;

endmodule
